// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the RAM-side bus of
// the memory arbiter.
// The master modport is the environment: the CPU, the debug/loader port and
// the RAM data return. The slave modport is the arbiter itself.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // CPU port (port 0)
    logic                  p0_req;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic                  p0_ack;

    // Debug/loader port (port 1)
    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic [DATA_WIDTH-1:0] p1_rdata;
    logic                  p1_ack;

    // RAM side
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Status
    logic                  busy;
    logic                  grant;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ram_rdata,
        input  p0_rdata, p0_ack, p1_rdata, p1_ack,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  busy, grant
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ram_rdata,
        output p0_rdata, p0_ack, p1_rdata, p1_ack,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output busy, grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM between the CPU port (0) and the debug/loader
// port (1).
// Each access runs through IDLE -> ACCESS -> DONE. The RAM strobe is held for
// RAM_LATENCY cycles. The winner then gets a one-cycle ack carrying the read
// data.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: when defined, ties alternate between
// the ports. When it is undefined, port 0 always wins a tie.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.slave    io_bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [2:0]            r_count;
    logic                  r_grant;
    logic                  r_busy;
    logic                  r_ramEn;
    logic                  r_ramWe;
    logic [ADDR_WIDTH-1:0] r_ramAddr;
    logic [DATA_WIDTH-1:0] r_ramWdata;
    logic [DATA_WIDTH-1:0] r_p0Rdata;
    logic [DATA_WIDTH-1:0] r_p1Rdata;
    logic                  r_p0Ack;
    logic                  r_p1Ack;

    logic                  w_anyReq;
    logic                  w_pick;
    logic                  w_accept;
    logic                  w_countZero;

    assign w_anyReq    = io_bus.p0_req | io_bus.p1_req;
    assign w_accept    = (r_state == IDLE) && w_anyReq;
    assign w_countZero = (r_count == 3'd0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_lastGrant;

    // Tie goes to the port not granted last; a lone requester always wins
    always_comb begin
        w_pick = io_bus.p1_req;
        if (io_bus.p0_req && io_bus.p1_req) begin
            w_pick = ~r_lastGrant;
        end
    end

    // Grant history; port 0 counts as last granted after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGrant <= 1'b0;
        end else if (w_accept) begin
            r_lastGrant <= w_pick;
        end
    end
`else
    // Fixed priority: port 1 is picked only when port 0 is not requesting
    always_comb begin
        w_pick = ~io_bus.p0_req;
    end
`endif

    // Next-state logic for the access sequencer
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq)    w_nextState = ACCESS;
            ACCESS:  if (w_countZero) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it is high exactly when state != IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_busy  <= (w_nextState != IDLE);
        end
    end

    // RAM bus, wait counter, grant and per-port read data / ack registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= 3'd0;
            r_grant    <= 1'b0;
            r_ramEn    <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
            r_p0Rdata  <= '0;
            r_p1Rdata  <= '0;
            r_p0Ack    <= 1'b0;
            r_p1Ack    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_grant    <= w_pick;
                        r_ramEn    <= 1'b1;
                        r_ramWe    <= w_pick ? io_bus.p1_we    : io_bus.p0_we;
                        r_ramAddr  <= w_pick ? io_bus.p1_addr  : io_bus.p0_addr;
                        r_ramWdata <= w_pick ? io_bus.p1_wdata : io_bus.p0_wdata;
                        r_count    <= 3'(RAM_LATENCY - 1);
                    end else begin
                        r_ramEn <= 1'b0;
                        r_ramWe <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (w_countZero) begin
                        r_ramEn <= 1'b0;
                        r_ramWe <= 1'b0;
                        if (r_grant) begin
                            r_p1Rdata <= io_bus.ram_rdata;
                            r_p1Ack   <= 1'b1;
                        end else begin
                            r_p0Rdata <= io_bus.ram_rdata;
                            r_p0Ack   <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                DONE: begin
                    r_p0Ack <= 1'b0;
                    r_p1Ack <= 1'b0;
                end
                default: begin
                    r_ramEn <= 1'b0;
                    r_ramWe <= 1'b0;
                    r_p0Ack <= 1'b0;
                    r_p1Ack <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.p0_rdata  = r_p0Rdata;
    assign io_bus.p0_ack    = r_p0Ack;
    assign io_bus.p1_rdata  = r_p1Rdata;
    assign io_bus.p1_ack    = r_p1Ack;
    assign io_bus.ram_en    = r_ramEn;
    assign io_bus.ram_we    = r_ramWe;
    assign io_bus.ram_addr  = r_ramAddr;
    assign io_bus.ram_wdata = r_ramWdata;
    assign io_bus.busy      = r_busy;
    assign io_bus.grant     = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// Two instances are used: one with RAM_LATENCY=1 and one with RAM_LATENCY=3.
// Each instance drives its own small RAM model. Outputs are sampled on the
// falling edge of the clock.
module tb_mem_arbiter;

    logic clk;
    logic rstA;
    logic rstB;

    int vectors;
    int miscompares;

    logic [7:0] memA [256];
    logic [7:0] memB [256];

    mem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) ifA ();
    mem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) ifB ();

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RAM_LATENCY(1)) dutA (
        .clk    (clk),
        .reset  (rstA),
        .io_bus (ifA)
    );

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RAM_LATENCY(3)) dutB (
        .clk    (clk),
        .reset  (rstB),
        .io_bus (ifB)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: combinational read, write on posedge while strobed; preloaded under reset
    assign ifA.ram_rdata = memA[ifA.ram_addr];
    assign ifB.ram_rdata = memB[ifB.ram_addr];

    always @(posedge clk) begin
        if (rstA) begin
            memA[8'h10] <= 8'hA5;
            memA[8'h20] <= 8'h33;
        end else if (ifA.ram_en && ifA.ram_we) begin
            memA[ifA.ram_addr] <= ifA.ram_wdata;
        end
    end

    always @(posedge clk) begin
        if (rstB) begin
            memB[8'h44] <= 8'h9E;
        end else if (ifB.ram_en && ifB.ram_we) begin
            memB[ifB.ram_addr] <= ifB.ram_wdata;
        end
    end

    // Observations captured by applyStimulus
    logic       obsRamEn, obsRamWe, obsGrant, obsBusy;
    logic [7:0] obsRamAddr, obsRamWdata, obsRdata;
    logic       obsOtherAck, obsAckGrant, obsRamEnAtAck;
    int         obsCycles;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One complete transaction on instance A, started on a falling edge while idle
    task automatic applyStimulus(input int port, input logic we,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        logic gotAck;
        gotAck    = 1'b0;
        obsCycles = 0;
        if (port == 0) begin
            ifA.p0_we = we; ifA.p0_addr = addr; ifA.p0_wdata = wdata; ifA.p0_req = 1'b1;
        end else begin
            ifA.p1_we = we; ifA.p1_addr = addr; ifA.p1_wdata = wdata; ifA.p1_req = 1'b1;
        end
        for (int c = 1; c <= 20 && !gotAck; c++) begin
            @(negedge clk);
            if (c == 1) begin
                obsRamEn    = ifA.ram_en;
                obsRamWe    = ifA.ram_we;
                obsRamAddr  = ifA.ram_addr;
                obsRamWdata = ifA.ram_wdata;
                obsGrant    = ifA.grant;
                obsBusy     = ifA.busy;
            end
            if ((port == 0) ? ifA.p0_ack : ifA.p1_ack) begin
                gotAck        = 1'b1;
                obsCycles     = c;
                obsRdata      = (port == 0) ? ifA.p0_rdata : ifA.p1_rdata;
                obsOtherAck   = (port == 0) ? ifA.p1_ack : ifA.p0_ack;
                obsAckGrant   = ifA.grant;
                obsRamEnAtAck = ifA.ram_en;
                if (port == 0) ifA.p0_req = 1'b0;
                else           ifA.p1_req = 1'b0;
            end
        end
        if (!gotAck) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
            ifA.p0_req = 1'b0;
            ifA.p1_req = 1'b0;
        end
        @(negedge clk);
    endtask

    int         expWin [4];
    logic [7:0] expP0, expP1;
    int         winner;
    int         ackCount, enPulses;
    logic       prevEn, gotB;

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expWin = '{1, 0, 1, 0};
`else
        expWin = '{0, 0, 0, 0};
`endif
        vectors = 0;
        miscompares = 0;
        ifA.p0_req = 0; ifA.p0_we = 0; ifA.p0_addr = 0; ifA.p0_wdata = 0;
        ifA.p1_req = 0; ifA.p1_we = 0; ifA.p1_addr = 0; ifA.p1_wdata = 0;
        ifB.p0_req = 0; ifB.p0_we = 0; ifB.p0_addr = 0; ifB.p0_wdata = 0;
        ifB.p1_req = 0; ifB.p1_we = 0; ifB.p1_addr = 0; ifB.p1_wdata = 0;
        rstA = 1'b1;
        rstB = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        checkOutput("rst_p0_ack",   ifA.p0_ack,   0);
        checkOutput("rst_p1_ack",   ifA.p1_ack,   0);
        checkOutput("rst_p0_rdata", ifA.p0_rdata, 0);
        checkOutput("rst_ram_en",   ifA.ram_en,   0);
        checkOutput("rst_ram_addr", ifA.ram_addr, 0);
        checkOutput("rst_busy",     ifA.busy,     0);
        checkOutput("rst_grant",    ifA.grant,    0);
        rstA = 1'b0;
        rstB = 1'b0;
        @(negedge clk);

        // p0 read of 0x10 (0xA5), latency 1
        applyStimulus(0, 1'b0, 8'h10, 8'h00);
        checkOutput("rd0_ram_en",    obsRamEn,      1);
        checkOutput("rd0_ram_we",    obsRamWe,      0);
        checkOutput("rd0_ram_addr",  obsRamAddr,    8'h10);
        checkOutput("rd0_busy",      obsBusy,       1);
        checkOutput("rd0_grant",     obsGrant,      0);
        checkOutput("rd0_latency",   obsCycles,     2);
        checkOutput("rd0_rdata",     obsRdata,      8'hA5);
        checkOutput("rd0_p1_ack",    obsOtherAck,   0);
        checkOutput("rd0_en_at_ack", obsRamEnAtAck, 0);
        checkOutput("rd0_idle_busy", ifA.busy,      0);
        checkOutput("rd0_idle_ack",  ifA.p0_ack,    0);

        // p1 write 0x3F <= 0x5C, then read it back
        applyStimulus(1, 1'b1, 8'h3F, 8'h5C);
        checkOutput("wr1_ram_we",    obsRamWe,    1);
        checkOutput("wr1_ram_addr",  obsRamAddr,  8'h3F);
        checkOutput("wr1_ram_wdata", obsRamWdata, 8'h5C);
        checkOutput("wr1_grant",     obsGrant,    1);
        checkOutput("wr1_mem",       memA[8'h3F], 8'h5C);
        applyStimulus(1, 1'b0, 8'h3F, 8'h00);
        checkOutput("rd1_rdata",     obsRdata,    8'h5C);
        checkOutput("rd1_grant",     obsAckGrant, 1);
        checkOutput("rd1_p0_ack",    obsOtherAck, 0);

        // Four simultaneous-request rounds from a fresh reset
        rstA = 1'b1;
        @(negedge clk);
        rstA = 1'b0;
        expP0 = 8'h00;
        expP1 = 8'h00;
        ifA.p0_we = 0; ifA.p0_addr = 8'h10;
        ifA.p1_we = 0; ifA.p1_addr = 8'h20;
        ifA.p0_req = 1'b1;
        ifA.p1_req = 1'b1;
        for (int r = 0; r < 4; r++) begin
            winner = -1;
            for (int c = 0; c < 20 && winner < 0; c++) begin
                @(negedge clk);
                if (ifA.p0_ack || ifA.p1_ack) begin
                    checkOutput($sformatf("tie%0d_both_ack", r), ifA.p0_ack & ifA.p1_ack, 0);
                    winner = ifA.p1_ack ? 1 : 0;
                end
            end
            if (winner < 0) begin
                checkOutput($sformatf("tie%0d_timeout", r), 0, 1);
                winner = expWin[r];
            end
            checkOutput($sformatf("tie%0d_winner", r), winner, expWin[r]);
            checkOutput($sformatf("tie%0d_grant", r), ifA.grant, expWin[r]);
            if (winner == 1) expP1 = 8'h33;
            else             expP0 = 8'hA5;
            checkOutput($sformatf("tie%0d_p0_rdata", r), ifA.p0_rdata, expP0);
            checkOutput($sformatf("tie%0d_p1_rdata", r), ifA.p1_rdata, expP1);
            if (winner == 1) ifA.p1_req = 1'b0;
            else             ifA.p0_req = 1'b0;
            @(negedge clk);
            if (r < 3) begin
                if (winner == 1) ifA.p1_req = 1'b1;
                else             ifA.p0_req = 1'b1;
            end
        end
        // The still-pending p1 request is served once p0 has dropped
        ifA.p0_req = 1'b0;
        gotB = 1'b0;
        for (int c = 0; c < 20 && !gotB; c++) begin
            @(negedge clk);
            if (ifA.p1_ack) gotB = 1'b1;
        end
        checkOutput("tail_p1_ack",   gotB,         1);
        checkOutput("tail_grant",    ifA.grant,    1);
        checkOutput("tail_p1_rdata", ifA.p1_rdata, 8'h33);
        ifA.p1_req = 1'b0;
        @(negedge clk);

        // Latency 3: ram_en held 3 cycles, ack on the 4th
        ifB.p0_we = 0; ifB.p0_addr = 8'h44; ifB.p0_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                checkOutput($sformatf("lat3_c%0d_ram_en", c),   ifB.ram_en,   1);
                checkOutput($sformatf("lat3_c%0d_ram_addr", c), ifB.ram_addr, 8'h44);
                checkOutput($sformatf("lat3_c%0d_busy", c),     ifB.busy,     1);
                checkOutput($sformatf("lat3_c%0d_ack", c),      ifB.p0_ack,   0);
            end else begin
                checkOutput("lat3_ack",    ifB.p0_ack,   1);
                checkOutput("lat3_rdata",  ifB.p0_rdata, 8'h9E);
                checkOutput("lat3_busy",   ifB.busy,     1);
                checkOutput("lat3_ram_en", ifB.ram_en,   0);
                ifB.p0_req = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("lat3_idle_busy", ifB.busy,   0);
        checkOutput("lat3_idle_ack",  ifB.p0_ack, 0);

        // Reset during ACCESS of a p1 write, then re-request
        ifB.p1_we = 1; ifB.p1_addr = 8'h50; ifB.p1_wdata = 8'h77; ifB.p1_req = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_ram_en_pre", ifB.ram_en, 1);
        checkOutput("rstmid_ram_we_pre", ifB.ram_we, 1);
        rstB = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_ram_en", ifB.ram_en, 0);
        checkOutput("rstmid_busy",   ifB.busy,   0);
        checkOutput("rstmid_p1_ack", ifB.p1_ack, 0);
        rstB = 1'b0;
        obsCycles = 0;
        for (int c = 1; c <= 20 && obsCycles == 0; c++) begin
            @(negedge clk);
            if (ifB.p1_ack) obsCycles = c;
        end
        checkOutput("rstmid_reissue_latency", obsCycles,   4);
        checkOutput("rstmid_grant",           ifB.grant,   1);
        checkOutput("rstmid_mem",             memB[8'h50], 8'h77);
        ifB.p1_req = 1'b0;
        @(negedge clk);

        // p0 holds req one cycle past ack: second transaction
        ifA.p0_we = 0; ifA.p0_addr = 8'h10; ifA.p0_req = 1'b1;
        ackCount = 0;
        enPulses = 0;
        prevEn   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ifA.p0_ack) ackCount++;
            if (ifA.ram_en && !prevEn) enPulses++;
            prevEn = ifA.ram_en;
            if (c == 4) ifA.p0_req = 1'b0;
        end
        checkOutput("hold_ack_count", ackCount,     2);
        checkOutput("hold_en_pulses", enPulses,     2);
        checkOutput("hold_rdata",     ifA.p0_rdata, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
